// File: rtl/blvidpack.sv
// blvidpack - downstream packer for the camera's 80-bit pixel stream.
// Each accepted 10-pixel word is tagged with start-of-line / start-of-frame,
// buffered in a FIFO and serialised as five 16-bit beats on ready/valid.
// Line/frame geometry and a sticky overflow flag are reported alongside.
//
// Ports:
//   clk, rst        pixel clock, asynchronous active-high reset
//   id[79:0]        pixel word, id[7:0] = pixel 0
//   wrl, wrf        word strobe (line) and frame-active level
//   ordy            downstream ready
//   od[15:0], oval  output beat and its valid
//   osol, osof      start of line / frame, only on beat 0 of the tagged word
//   oovf            sticky overflow, cleared on wrf rise
//   olinelen[7:0]   word count of the last completed line
//   onlines[10:0]   line count of the last completed frame
module blvidpack #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] id,
  input  logic        wrl,
  input  logic        wrf,
  input  logic        ordy,
  output logic [15:0] od,
  output logic        oval,
  output logic        osol,
  output logic        osof,
  output logic        oovf,
  output logic [7:0]  olinelen,
  output logic [10:0] onlines
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};

  typedef enum logic {S_IDLE, S_SEND} state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [15:0] beat_sel(input logic [81:0] e, input logic [2:0] b);
    case (b)
      3'd0:    return e[15:0];
      3'd1:    return e[31:16];
      3'd2:    return e[47:32];
      3'd3:    return e[63:48];
      default: return e[79:64];
    endcase
  endfunction

  // entry layout: [81] sof, [80] sol, [79:0] pixel word
  logic [81:0]   mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;

  logic          wrl_q, wrf_q, in_line_q, in_line_d, in_frame_q, in_frame_d;
  logic          accept, wrl_fall, wrf_rise, wrf_fall, line_end;
  logic          vld_p0;
  logic [81:0]   ent_p0, wr_ent;
  logic          full, wr_en, drop, pop;
  logic [1:0]    pend_q, pend_d;
  logic          oovf_q, oovf_d;

  state_t        state_q, state_d;
  logic [2:0]    beat_q, beat_d;
  logic [81:0]   hold_q, hold_d;
  logic [15:0]   od_q, od_d;
  logic          oval_q, oval_d, osol_q, osol_d, osof_q, osof_d;

  logic [7:0]    wc_q, wc_d, linelen_q, linelen_d;
  logic [10:0]   lc_q, lc_d, nlines_q, nlines_d;

  assign accept   = wrl & wrf;
  assign wrl_fall = wrl_q & ~wrl;
  assign wrf_rise = wrf & ~wrf_q;
  assign wrf_fall = wrf_q & ~wrf;
  // using the registered wrf makes a line that ends with the frame still count
  assign line_end = wrl_fall & wrf_q;

  // in_line/in_frame remember that a word has already been taken in this run
  assign in_line_d  = wrl & (in_line_q | accept);
  assign in_frame_d = wrf & (in_frame_q | accept);

  // ---- stage p0 -> FIFO write ----
  assign full   = (count_q == FULL_CNT);
  assign wr_en  = vld_p0 & ~full;
  assign drop   = vld_p0 & full;
  assign wr_ent = {ent_p0[81:80] | pend_q, ent_p0[79:0]};

  always_comb begin
    pend_d = pend_q;
    if (drop)       pend_d = pend_q | ent_p0[81:80];
    else if (wr_en) pend_d = 2'b00;
    oovf_d = wrf_rise ? 1'b0 : oovf_q;
    if (drop) oovf_d = 1'b1;
  end

  // ---- FIFO -> serialiser ----
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    hold_d  = hold_q;
    oval_d  = oval_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          hold_d  = mem[rptr_q];
          beat_d  = 3'd0;
          oval_d  = 1'b1;
          state_d = S_SEND;
        end
      end
      default: begin
        if (ordy) begin
          if (beat_q == 3'd4) begin
            if (count_q != '0) begin
              pop    = 1'b1;
              hold_d = mem[rptr_q];
              beat_d = 3'd0;
            end else begin
              oval_d  = 1'b0;
              state_d = S_IDLE;
            end
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
    endcase
    od_d   = oval_d ? beat_sel(hold_d, beat_d) : 16'd0;
    osol_d = oval_d & hold_d[80] & (beat_d == 3'd0);
    osof_d = oval_d & hold_d[81] & (beat_d == 3'd0);
  end

  always_comb begin
    wptr_d  = wr_en ? wptr_q + PTR_ONE : wptr_q;
    rptr_d  = pop ? rptr_q + PTR_ONE : rptr_q;
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // ---- geometry counters ----
  always_comb begin
    wc_d      = wc_q;
    lc_d      = lc_q;
    linelen_d = linelen_q;
    nlines_d  = nlines_q;
    if (accept) wc_d = sat_inc8(wc_q);
    if (line_end) begin
      linelen_d = wc_q;
      lc_d      = sat_inc11(lc_q);
      wc_d      = 8'd0;
    end
    if (wrf_fall) nlines_d = line_end ? sat_inc11(lc_q) : lc_q;
    if (wrf_rise) begin
      lc_d = 11'd0;
      wc_d = accept ? 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrl_q      <= 1'b0;
      wrf_q      <= 1'b0;
      in_line_q  <= 1'b0;
      in_frame_q <= 1'b0;
      vld_p0     <= 1'b0;
      pend_q     <= 2'b00;
      oovf_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      beat_q     <= 3'd0;
      od_q       <= 16'd0;
      oval_q     <= 1'b0;
      osol_q     <= 1'b0;
      osof_q     <= 1'b0;
      wc_q       <= 8'd0;
      lc_q       <= 11'd0;
      linelen_q  <= 8'd0;
      nlines_q   <= 11'd0;
    end else begin
      wrl_q      <= wrl;
      wrf_q      <= wrf;
      in_line_q  <= in_line_d;
      in_frame_q <= in_frame_d;
      vld_p0     <= accept;
      pend_q     <= pend_d;
      oovf_q     <= oovf_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      beat_q     <= beat_d;
      od_q       <= od_d;
      oval_q     <= oval_d;
      osol_q     <= osol_d;
      osof_q     <= osof_d;
      wc_q       <= wc_d;
      lc_q       <= lc_d;
      linelen_q  <= linelen_d;
      nlines_q   <= nlines_d;
    end
  end

  // ---- input -> stage p0 (tags computed against the pre-edge run state) ----
  always_ff @(posedge clk) begin
    ent_p0 <= {~in_frame_q, ~in_line_q, id};
    if (wr_en) mem[wptr_q] <= wr_ent;
    hold_q <= hold_d;
  end

  assign od       = od_q;
  assign oval     = oval_q;
  assign osol     = osol_q;
  assign osof     = osof_q;
  assign oovf     = oovf_q;
  assign olinelen = linelen_q;
  assign onlines  = nlines_q;

endmodule
